jt12_timer_pair: RTL

//  Timer A / timer B pair of the YM2612/YM2203 core, directly downstream of the clock divider.

---
 rtl/jt12_timer_pair.sv | 80 ++++++++
 1 files changed

// File: rtl/jt12_timer_pair.sv
// jt12_timer_pair: YM2612/YM2203 timer A / timer B pair with status flags, IRQ and CSM overflow pulse
module jt12_timer_pair #(
    parameter int SLOT_DIV = 24,
    parameter int B_PRESC  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [9:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       en_flag_A,
    input  logic       en_flag_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n
);
    localparam int SW = $clog2(SLOT_DIV);
    localparam int PW = $clog2(B_PRESC);

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [PW-1:0] presc_b_q, presc_b_d;
    logic [9:0]    cnt_a_q, cnt_a_d;
    logic [7:0]    cnt_b_q, cnt_b_d;
    logic          load_a_l_q, load_b_l_q;
    logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic          overflow_a_q, overflow_a_d;
    logic          tick_a, tick_b, edge_a, edge_b, ovf_a, ovf_b;

    // Sample tick, prescaler, timer counters and flag next-state; a load edge masks a same-cycle tick
    always_comb begin
        tick_a       = clk_en && slot_cnt_q == SW'(SLOT_DIV - 1);
        tick_b       = tick_a && presc_b_q == PW'(B_PRESC - 1);
        edge_a       = load_A && !load_a_l_q;
        edge_b       = load_B && !load_b_l_q;
        ovf_a        = load_A && !edge_a && tick_a && &cnt_a_q;
        ovf_b        = load_B && !edge_b && tick_b && &cnt_b_q;
        slot_cnt_d   = !clk_en ? slot_cnt_q : tick_a ? '0 : slot_cnt_q + 1'b1;
        presc_b_d    = edge_b ? '0 : !(load_B && tick_a) ? presc_b_q : tick_b ? '0 : presc_b_q + 1'b1;
        cnt_a_d      = (edge_a || ovf_a) ? value_A : (load_A && tick_a) ? cnt_a_q + 1'b1 : cnt_a_q;
        cnt_b_d      = (edge_b || ovf_b) ? value_B : (load_B && tick_b) ? cnt_b_q + 1'b1 : cnt_b_q;
        flag_a_d     = (ovf_a && en_flag_A) || (flag_a_q && !clr_flag_A);
        flag_b_d     = (ovf_b && en_flag_B) || (flag_b_q && !clr_flag_B);
        overflow_a_d = ovf_a;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            presc_b_q    <= '0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            load_a_l_q   <= 1'b0;
            load_b_l_q   <= 1'b0;
            flag_a_q     <= 1'b0;
            flag_b_q     <= 1'b0;
            overflow_a_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            presc_b_q    <= presc_b_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            load_a_l_q   <= load_A;
            load_b_l_q   <= load_B;
            flag_a_q     <= flag_a_d;
            flag_b_q     <= flag_b_d;
            overflow_a_q <= overflow_a_d;
        end
    end

    assign flag_A     = flag_a_q;
    assign flag_B     = flag_b_q;
    assign overflow_A = overflow_a_q;
    assign irq_n      = ~(flag_a_q | flag_b_q);
endmodule
